// File: rtl/mcu_pkg.sv
// Purpose: shared state encoding and helpers for the mcu_seek player control unit.
// Contents: state_t, the PAUSE/PLAY/REWIND/FF encodings, and the play/pause inversion
// used when a seek is aborted by play_button.
package mcu_pkg;

   typedef logic [1:0] state_t;

   localparam state_t PAUSE  = 2'b00;
   localparam state_t PLAY   = 2'b01;
   localparam state_t REWIND = 2'b10;
   localparam state_t FF     = 2'b11;

   // A seek aborted by play_button lands in the opposite of its return state.
   function automatic state_t flip_ret(input state_t s);
      return (s == PLAY) ? PAUSE : PLAY;
   endfunction

endpackage

// File: rtl/mcu_seek_wrap_counter.sv
// Purpose: up/down modulo-N counter with enable. It wraps N-1 -> 0 going up and
// 0 -> N-1 going down. N does not need to be a power of two.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears the count
//   en    - advance the count this cycle
//   up    - direction (1 = increment, 0 = decrement)
//   cnt   - current count (registered)
module wrap_counter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         up,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX = W'(N - 1);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   // Next count with wrap in both directions.
   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         if (up) cnt_d = (cnt_q == MAX) ? '0 : cnt_q + W'(1);
         else    cnt_d = (cnt_q == '0) ? MAX : cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mcu_seek.sv
// Purpose: player control unit. It runs song selection with wrap and a
// play/pause/seek FSM. A rewind or ff request holds its output for SEEK_LEN cycles
// and then returns to the state the seek was entered from.
// Optional feature: define MCU_AUTOPLAY_EN so that a song change taken while
// playing (or during a seek that returns to PLAY) keeps playing.
// Ports:
//   clk, reset (async, active-low)
//   play_button, next_button, prev_button, rewind_button, ff_button - 1-cycle pulses
//   song_done    - end-of-song pulse from the player
//   play/rewind/ff - Moore decodes of the state register
//   reset_player - combinational; high in the cycle of any song change
//   song         - current song index
module mcu_seek
   import mcu_pkg::*;
#(
   parameter int unsigned NUM_SONGS = 4,
   parameter int unsigned SONG_W    = $clog2(NUM_SONGS),
   parameter int unsigned SEEK_LEN  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_button,
   input  logic              next_button,
   input  logic              prev_button,
   input  logic              rewind_button,
   input  logic              ff_button,
   input  logic              song_done,
   output logic              play,
   output logic              rewind,
   output logic              ff,
   output logic              reset_player,
   output logic [SONG_W-1:0] song
);

   localparam int unsigned       CNT_W    = $clog2(SEEK_LEN + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SEEK_LEN - 1);

`ifdef MCU_AUTOPLAY_EN
   localparam bit AUTOPLAY = 1'b1;
`else
   localparam bit AUTOPLAY = 1'b0;
`endif

   logic       chg;
   logic       song_up;
   logic       same_dir;
   logic       opp_dir;
   state_t     state_d, state_q;
   state_t     ret_d, ret_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // next_button and song_done win over prev_button for direction.
   assign chg     = next_button | prev_button | song_done;
   assign song_up = next_button | song_done;

   wrap_counter #(
      .N (NUM_SONGS),
      .W (SONG_W)
   ) u_song (
      .clk   (clk),
      .rst_n (reset),
      .en    (chg),
      .up    (song_up),
      .cnt   (song)
   );

   // State, seek counter and return state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= PAUSE;
         ret_q   <= PAUSE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   // Seek buttons in terms of the current seek direction.
   assign same_dir = (state_q == REWIND) ? rewind_button : ff_button;
   assign opp_dir  = (state_q == REWIND) ? ff_button     : rewind_button;

   // Next-state logic; priority chg > play > rewind > ff.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      case (state_q)
         PAUSE, PLAY: begin
            if (chg) begin
               state_d = (AUTOPLAY && state_q == PLAY) ? PLAY : PAUSE;
            end else if (play_button) begin
               state_d = flip_ret(state_q);
            end else if (rewind_button) begin
               state_d = REWIND;
               ret_d   = state_q;
               cnt_d   = CNT_LOAD;
            end else if (ff_button) begin
               state_d = FF;
               ret_d   = state_q;
               cnt_d   = CNT_LOAD;
            end
         end
         default: begin
            if (chg) begin
               state_d = (AUTOPLAY && ret_q == PLAY) ? PLAY : PAUSE;
            end else if (play_button) begin
               state_d = flip_ret(ret_q);
            end else if (same_dir) begin
               cnt_d = CNT_LOAD;
            end else if (opp_dir) begin
               state_d = (state_q == REWIND) ? FF : REWIND;
               cnt_d   = CNT_LOAD;
            end else if (cnt_q == '0) begin
               state_d = ret_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   // Moore decodes plus the combinational player restart.
   always_comb begin
      play         = (state_q == PLAY);
      rewind       = (state_q == REWIND);
      ff           = (state_q == FF);
      reset_player = chg & reset;
   end

endmodule

// File: tb/tb_mcu_seek.sv
// Directed bench for mcu_seek with NUM_SONGS=3 and SEEK_LEN=4. Each step pushes its
// expected outputs to a scoreboard queue. The entry is popped and compared after
// the clock edge.
module tb_mcu_seek;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       play_button = 1'b0, next_button = 1'b0, prev_button = 1'b0;
   logic       rewind_button = 1'b0, ff_button = 1'b0, song_done = 1'b0;
   logic       play, rewind, ff, reset_player;
   logic [1:0] song;

   int checks = 0;
   int errors = 0;

`ifdef MCU_AUTOPLAY_EN
   localparam bit AP = 1'b1;
`else
   localparam bit AP = 1'b0;
`endif

   // Button vector order: {play, next, prev, rewind, ff, done}
   localparam logic [5:0] B_NONE = 6'b000000;
   localparam logic [5:0] B_PLAY = 6'b100000;
   localparam logic [5:0] B_NEXT = 6'b010000;
   localparam logic [5:0] B_PREV = 6'b001000;
   localparam logic [5:0] B_REW  = 6'b000100;
   localparam logic [5:0] B_FF   = 6'b000010;
   localparam logic [5:0] B_DONE = 6'b000001;

   // Expected {play, rewind, ff}
   localparam logic [2:0] S_PAUSE = 3'b000;
   localparam logic [2:0] S_PLAY  = 3'b100;
   localparam logic [2:0] S_REW   = 3'b010;
   localparam logic [2:0] S_FF    = 3'b001;
   localparam logic [2:0] S_CHG   = AP ? S_PLAY : S_PAUSE;

   typedef struct {
      string      tag;
      logic [4:0] exp;
   } exp_t;

   exp_t sb[$];

   mcu_seek #(
      .NUM_SONGS (3),
      .SONG_W    (2),
      .SEEK_LEN  (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .play_button   (play_button),
      .next_button   (next_button),
      .prev_button   (prev_button),
      .rewind_button (rewind_button),
      .ff_button     (ff_button),
      .song_done     (song_done),
      .play          (play),
      .rewind        (rewind),
      .ff            (ff),
      .reset_player  (reset_player),
      .song          (song)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed {play,rew,ff,song}=%b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_rp(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s reset_player: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one cycle of buttons, check reset_player in-cycle, then outputs after the edge.
   task automatic cyc(input string tag, input logic [5:0] btn, input logic exp_rp,
                      input logic [4:0] exp);
      exp_t item;
      @(negedge clk);
      {play_button, next_button, prev_button, rewind_button, ff_button, song_done} = btn;
      #1;
      chk_rp(tag, reset_player, exp_rp);
      item.tag = tag;
      item.exp = exp;
      sb.push_back(item);
      @(posedge clk);
      #1;
      item = sb.pop_front();
      chk(item.tag, {play, rewind, ff, song}, item.exp);
   endtask

   initial begin
      // Reset state, and reset_player is forced low during reset.
      #2 next_button = 1'b1;
      #1;
      chk("reset_state", {play, rewind, ff, song}, {S_PAUSE, 2'd0});
      chk_rp("reset_low", reset_player, 1'b0);
      next_button = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // Song wrap both ways with NUM_SONGS=3.
      cyc("next1", B_NEXT, 1'b1, {S_PAUSE, 2'd1});
      cyc("next2", B_NEXT, 1'b1, {S_PAUSE, 2'd2});
      cyc("next3_wrap", B_NEXT, 1'b1, {S_PAUSE, 2'd0});
      cyc("prev_wrap", B_PREV, 1'b1, {S_PAUSE, 2'd2});
      cyc("prev", B_PREV, 1'b1, {S_PAUSE, 2'd1});

      // FF from PLAY lasts exactly SEEK_LEN cycles.
      cyc("play", B_PLAY, 1'b0, {S_PLAY, 2'd1});
      cyc("ff_c1", B_FF, 1'b0, {S_FF, 2'd1});
      cyc("ff_c2", B_NONE, 1'b0, {S_FF, 2'd1});
      cyc("ff_c3", B_NONE, 1'b0, {S_FF, 2'd1});
      cyc("ff_c4", B_NONE, 1'b0, {S_FF, 2'd1});
      cyc("ff_ret", B_NONE, 1'b0, {S_PLAY, 2'd1});

      // Re-pulse on the 2nd ff cycle extends to 6 cycles.
      cyc("ext_c1", B_FF, 1'b0, {S_FF, 2'd1});
      cyc("ext_c2", B_NONE, 1'b0, {S_FF, 2'd1});
      cyc("ext_c3", B_FF, 1'b0, {S_FF, 2'd1});
      cyc("ext_c4", B_NONE, 1'b0, {S_FF, 2'd1});
      cyc("ext_c5", B_NONE, 1'b0, {S_FF, 2'd1});
      cyc("ext_c6", B_NONE, 1'b0, {S_FF, 2'd1});
      cyc("ext_ret", B_NONE, 1'b0, {S_PLAY, 2'd1});

      // Switching FF -> REWIND reloads the count and keeps the return state.
      cyc("sw_ff", B_FF, 1'b0, {S_FF, 2'd1});
      cyc("sw_rew1", B_REW, 1'b0, {S_REW, 2'd1});
      cyc("sw_rew2", B_NONE, 1'b0, {S_REW, 2'd1});
      cyc("sw_rew3", B_NONE, 1'b0, {S_REW, 2'd1});
      cyc("sw_rew4", B_NONE, 1'b0, {S_REW, 2'd1});
      cyc("sw_ret", B_NONE, 1'b0, {S_PLAY, 2'd1});

      // next beats prev; play beats rewind.
      cyc("pause", B_PLAY, 1'b0, {S_PAUSE, 2'd1});
      cyc("next_prev", B_NEXT | B_PREV, 1'b1, {S_PAUSE, 2'd2});
      cyc("play_rew", B_PLAY | B_REW, 1'b0, {S_PLAY, 2'd2});

      // song_done in PLAY at the last song wraps to 0.
      cyc("done_wrap", B_DONE, 1'b1, {S_CHG, 2'd0});
      cyc("prev_to2", B_PREV, 1'b1, {S_CHG, 2'd2});

      // Async reset mid-FF.
      cyc("pre_rst_ff", B_FF, 1'b0, {S_FF, 2'd2});
      cyc("pre_rst_ff2", B_NONE, 1'b0, {S_FF, 2'd2});
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_reset", {play, rewind, ff, song}, {S_PAUSE, 2'd0});
      @(posedge clk);
      #1;
      chk("reset_held", {play, rewind, ff, song}, {S_PAUSE, 2'd0});
      @(negedge clk);
      reset = 1'b1;

      // FF from PAUSE returns to PAUSE after SEEK_LEN cycles.
      cyc("pff_c1", B_FF, 1'b0, {S_FF, 2'd0});
      cyc("pff_c2", B_NONE, 1'b0, {S_FF, 2'd0});
      cyc("pff_c3", B_NONE, 1'b0, {S_FF, 2'd0});
      cyc("pff_c4", B_NONE, 1'b0, {S_FF, 2'd0});
      cyc("pff_ret", B_NONE, 1'b0, {S_PAUSE, 2'd0});

      // play aborts a seek into the inverse of its return state.
      cyc("abort_ff", B_FF, 1'b0, {S_FF, 2'd0});
      cyc("abort_play", B_PLAY, 1'b0, {S_PLAY, 2'd0});

      // Song change aborts a seek whose return state is PLAY.
      cyc("chg_rew", B_REW, 1'b0, {S_REW, 2'd0});
      cyc("chg_abort", B_NEXT, 1'b1, {S_CHG, 2'd1});
      cyc("idle_end", B_NONE, 1'b0, {S_CHG, 2'd1});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
